// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared types and constants for the pipelined execute stage.
//   alu_op_t : 3-bit ALU operation encoding (AND .. MUL)
//   state_t  : iterative multiplier control states
//   ALU_OP_W : width of the operation code
// -----------------------------------------------------------------------------
package exe_pkg;

   localparam int ALU_OP_W = 3;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_AND = 3'b000,
      ALU_ADD = 3'b001,
      ALU_SUB = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_MUL = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_ext.sv
// -----------------------------------------------------------------------------
// alu_ext
// Combinational single-cycle ALU for every operation except MUL.
// Ports:
//   i_a      : operand A
//   i_b      : operand B (already muxed between register and immediate)
//   i_op     : operation code
//   o_result : result, wraps modulo 2^WIDTH
//   o_ovf    : signed overflow for ADD/SUB, 0 for every other op
// -----------------------------------------------------------------------------
module alu_ext
   import exe_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  alu_op_t          i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_ovf
);

   logic signed [WIDTH-1:0] w_a_s;
   logic signed [WIDTH-1:0] w_b_s;
   logic        [WIDTH-1:0] w_sum;
   logic        [WIDTH-1:0] w_diff;
   logic                    w_lt;
   logic        [SHAMT_W-1:0] w_shamt;

   assign w_a_s   = $signed(i_a);
   assign w_b_s   = $signed(i_b);
   assign w_sum   = i_a + i_b;
   assign w_diff  = i_a - i_b;
   assign w_lt    = (w_a_s < w_b_s);
   assign w_shamt = i_b[SHAMT_W-1:0];

   always_comb begin
      o_result = '0;
      o_ovf    = 1'b0;
      case (i_op)
         ALU_AND: o_result = i_a & i_b;
         ALU_ADD: begin
            o_result = w_sum;
            // Same-sign operands whose sum flips sign.
            o_ovf    = (w_a_s[WIDTH-1] == w_b_s[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         ALU_SUB: begin
            o_result = w_diff;
            // Opposite-sign operands whose difference loses A's sign.
            o_ovf    = (w_a_s[WIDTH-1] != w_b_s[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != i_a[WIDTH-1]);
         end
         ALU_OR:  o_result = i_a | i_b;
         ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
         ALU_SLL: o_result = i_a << w_shamt;
         ALU_SRL: o_result = i_a >> w_shamt;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/exe_stage_pipe.sv
// -----------------------------------------------------------------------------
// exe_stage_pipe
// Execute stage with a registered EX/MEM result, valid/ready handshakes on
// both sides and an iterative shift-add multiplier (WIDTH cycles + 1).
// Ports:
//   clk, rst_n            : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   : upstream handshake for operands and control
//   value_a, value_b      : register operands
//   immediate, alu_src    : sign-extended immediate and B-operand select
//   alu_op                : 3-bit operation code
//   flush                 : drop in-flight multiply and held result
//   out_valid / out_ready : downstream handshake for the result register
//   alu_result            : registered result
//   flag_zero/neg/ovf     : flags registered alongside alu_result
// -----------------------------------------------------------------------------
module exe_stage_pipe
   import exe_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    value_a,
   input  logic [WIDTH-1:0]    value_b,
   input  logic [WIDTH-1:0]    immediate,
   input  logic                alu_src,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    alu_result,
   output logic                flag_zero,
   output logic                flag_neg,
   output logic                flag_ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_neg;
   logic               r_ovf;

   alu_op_t            w_op;
   logic [WIDTH-1:0]   w_b;
   logic [WIDTH-1:0]   w_alu_res;
   logic               w_alu_ovf;
   logic               w_out_free;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_wr_en;
   logic [WIDTH-1:0]   w_wr_data;
   logic               w_wr_ovf;

   assign w_op       = alu_op_t'(alu_op);
   assign w_b        = alu_src ? immediate : value_b;
   assign w_is_mul   = (w_op == ALU_MUL);
   // Output slot is usable if empty or being drained this cycle.
   assign w_out_free = !r_out_valid || out_ready;
   assign in_ready   = (r_state == IDLE) && w_out_free && !flush;
   assign w_accept   = in_valid && in_ready;

   alu_ext #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_alu (
      .i_a      (value_a),
      .i_b      (w_b),
      .i_op     (w_op),
      .o_result (w_alu_res),
      .o_ovf    (w_alu_ovf)
   );

   // ---- multiplier control: next state ----
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept && w_is_mul) w_state_nxt = MUL;
         MUL:  if (r_cnt == CNT_W'(1))   w_state_nxt = DONE;
         DONE: if (w_out_free)           w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
      if (flush) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---- multiplier datapath: one shift-add step per cycle ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_accept && w_is_mul) begin
         r_mcand  <= value_a;
         r_mplier <= w_b;
         r_acc    <= '0;
         r_cnt    <= CNT_W'(WIDTH);
      end else if (r_state == MUL) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - CNT_W'(1);
      end
   end

   // Single-cycle ops and a finished multiply never compete: DONE blocks accepts.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_data = w_alu_res;
      w_wr_ovf  = w_alu_ovf;
      if (w_accept && !w_is_mul) begin
         w_wr_en = 1'b1;
      end else if ((r_state == DONE) && w_out_free && !flush) begin
         w_wr_en   = 1'b1;
         w_wr_data = r_acc;
         w_wr_ovf  = 1'b0;
      end
   end

   // ---- EX/MEM result register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_wr_en) begin
         r_out_valid <= 1'b1;
         r_result    <= w_wr_data;
         r_zero      <= (w_wr_data == '0);
         r_neg       <= w_wr_data[WIDTH-1];
         r_ovf       <= w_wr_ovf;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign alu_result = r_result;
   assign flag_zero  = r_zero;
   assign flag_neg   = r_neg;
   assign flag_ovf   = r_ovf;

endmodule
